// File: rtl/gip_rfw_writeback.sv
// Register-file write-back: merges mem-read and ALU results onto one write port with a one-entry ALU hold.
// Optional forwarding of the last write is enabled by defining GIP_RFW_FORWARD_EN.
module gip_rfw_writeback #(
  parameter int         DATA_WIDTH   = 32,
  parameter logic [2:0] RD_TYPE_NONE = 3'b000
) (
  input  logic                  gip_clock,
  input  logic                  gip_reset,
  input  logic [2:0]            alu_rd__type,
  input  logic [4:0]            alu_rd__r,
  input  logic                  alu_use_shifter,
  input  logic [DATA_WIDTH-1:0] alu_shifter_result,
  input  logic [DATA_WIDTH-1:0] alu_arith_logic_result,
  input  logic [2:0]            mem_rfw_rd__type,
  input  logic [4:0]            mem_rfw_rd__r,
  input  logic [DATA_WIDTH-1:0] mem_rfw_data,
  output logic                  rfw_accepting_alu_rd,
  output logic                  rf_write_enable,
  output logic [2:0]            rf_write_rd__type,
  output logic [4:0]            rf_write_rd__r,
  output logic [DATA_WIDTH-1:0] rf_write_data,
  output logic [2:0]            rfw_rd__type,
  output logic [4:0]            rfw_rd__r,
  output logic [DATA_WIDTH-1:0] rfw_data
);

  logic                  hold_valid_reg, hold_valid_next;
  logic [2:0]            hold_type_reg, hold_type_next;
  logic [4:0]            hold_r_reg, hold_r_next;
  logic [DATA_WIDTH-1:0] hold_data_reg, hold_data_next;

  logic                  wr_en_reg, wr_en_next;
  logic [2:0]            wr_type_reg, wr_type_next;
  logic [4:0]            wr_r_reg, wr_r_next;
  logic [DATA_WIDTH-1:0] wr_data_reg, wr_data_next;

  logic                  mem_valid, alu_valid, alu_take;
  logic [DATA_WIDTH-1:0] alu_data;
  logic                  hold_hits_mem, alu_hits_mem;

  assign mem_valid     = (mem_rfw_rd__type != RD_TYPE_NONE);
  assign alu_valid     = (alu_rd__type != RD_TYPE_NONE);
  assign alu_data      = alu_use_shifter ? alu_shifter_result : alu_arith_logic_result;
  assign hold_hits_mem = (hold_type_reg == mem_rfw_rd__type) && (hold_r_reg == mem_rfw_rd__r);
  assign alu_hits_mem  = (alu_rd__type == mem_rfw_rd__type) && (alu_rd__r == mem_rfw_rd__r);

  // Accept depends only on hold occupancy and mem activity, never on the ALU inputs.
  assign rfw_accepting_alu_rd = gip_reset | ~hold_valid_reg | ~mem_valid;
  assign alu_take             = alu_valid & rfw_accepting_alu_rd;

  always_comb begin
    hold_valid_next = hold_valid_reg;
    hold_type_next  = hold_type_reg;
    hold_r_next     = hold_r_reg;
    hold_data_next  = hold_data_reg;
    wr_en_next      = 1'b0;
    wr_type_next    = wr_type_reg;
    wr_r_next       = wr_r_reg;
    wr_data_next    = wr_data_reg;
    if (mem_valid) begin
      wr_en_next = 1'b1;
      if (hold_valid_reg && hold_hits_mem) begin
        // The held ALU result is younger than the mem result to the same register: it wins.
        wr_type_next    = hold_type_reg;
        wr_r_next       = hold_r_reg;
        wr_data_next    = hold_data_reg;
        hold_valid_next = 1'b0;
      end else if (!hold_valid_reg && alu_take && alu_hits_mem) begin
        wr_type_next = alu_rd__type;
        wr_r_next    = alu_rd__r;
        wr_data_next = alu_data;
      end else begin
        wr_type_next = mem_rfw_rd__type;
        wr_r_next    = mem_rfw_rd__r;
        wr_data_next = mem_rfw_data;
        if (!hold_valid_reg && alu_take) begin
          hold_valid_next = 1'b1;
          hold_type_next  = alu_rd__type;
          hold_r_next     = alu_rd__r;
          hold_data_next  = alu_data;
        end
      end
    end else if (hold_valid_reg) begin
      wr_en_next      = 1'b1;
      wr_type_next    = hold_type_reg;
      wr_r_next       = hold_r_reg;
      wr_data_next    = hold_data_reg;
      hold_valid_next = alu_take;
      if (alu_take) begin
        hold_type_next = alu_rd__type;
        hold_r_next    = alu_rd__r;
        hold_data_next = alu_data;
      end
    end else if (alu_take) begin
      wr_en_next   = 1'b1;
      wr_type_next = alu_rd__type;
      wr_r_next    = alu_rd__r;
      wr_data_next = alu_data;
    end
  end

  always_ff @(posedge gip_clock) begin
    if (gip_reset) begin
      hold_valid_reg <= 1'b0;
      hold_type_reg  <= RD_TYPE_NONE;
      hold_r_reg     <= '0;
      hold_data_reg  <= '0;
      wr_en_reg      <= 1'b0;
      wr_type_reg    <= RD_TYPE_NONE;
      wr_r_reg       <= '0;
      wr_data_reg    <= '0;
    end else begin
      hold_valid_reg <= hold_valid_next;
      hold_type_reg  <= hold_type_next;
      hold_r_reg     <= hold_r_next;
      hold_data_reg  <= hold_data_next;
      wr_en_reg      <= wr_en_next;
      wr_type_reg    <= wr_type_next;
      wr_r_reg       <= wr_r_next;
      wr_data_reg    <= wr_data_next;
    end
  end

  assign rf_write_enable   = wr_en_reg;
  assign rf_write_rd__type = wr_type_reg;
  assign rf_write_rd__r    = wr_r_reg;
  assign rf_write_data     = wr_data_reg;

`ifdef GIP_RFW_FORWARD_EN
  always_comb begin
    rfw_rd__type = RD_TYPE_NONE;
    rfw_rd__r    = '0;
    rfw_data     = '0;
    if (wr_en_reg) begin
      rfw_rd__type = wr_type_reg;
      rfw_rd__r    = wr_r_reg;
      rfw_data     = wr_data_reg;
    end else if (hold_valid_reg) begin
      rfw_rd__type = hold_type_reg;
      rfw_rd__r    = hold_r_reg;
      rfw_data     = hold_data_reg;
    end
  end
`else
  assign rfw_rd__type = RD_TYPE_NONE;
  assign rfw_rd__r    = '0;
  assign rfw_data     = '0;
`endif

endmodule

// File: tb/tb_gip_rfw_writeback.sv
// Self-checking bench for gip_rfw_writeback: directed test-plan scenarios plus randomized traffic
// checked every cycle against a queue-based reference model.
module tb_gip_rfw_writeback;

  logic        gip_clock = 1'b0;
  logic        gip_reset = 1'b1;
  logic [2:0]  alu_rd__type = '0;
  logic [4:0]  alu_rd__r = '0;
  logic        alu_use_shifter = 1'b0;
  logic [31:0] alu_shifter_result = '0;
  logic [31:0] alu_arith_logic_result = '0;
  logic [2:0]  mem_rfw_rd__type = '0;
  logic [4:0]  mem_rfw_rd__r = '0;
  logic [31:0] mem_rfw_data = '0;
  logic        rfw_accepting_alu_rd;
  logic        rf_write_enable;
  logic [2:0]  rf_write_rd__type;
  logic [4:0]  rf_write_rd__r;
  logic [31:0] rf_write_data;
  logic [2:0]  rfw_rd__type;
  logic [4:0]  rfw_rd__r;
  logic [31:0] rfw_data;

  gip_rfw_writeback dut (
    .gip_clock(gip_clock), .gip_reset(gip_reset),
    .alu_rd__type(alu_rd__type), .alu_rd__r(alu_rd__r), .alu_use_shifter(alu_use_shifter),
    .alu_shifter_result(alu_shifter_result), .alu_arith_logic_result(alu_arith_logic_result),
    .mem_rfw_rd__type(mem_rfw_rd__type), .mem_rfw_rd__r(mem_rfw_rd__r), .mem_rfw_data(mem_rfw_data),
    .rfw_accepting_alu_rd(rfw_accepting_alu_rd), .rf_write_enable(rf_write_enable),
    .rf_write_rd__type(rf_write_rd__type), .rf_write_rd__r(rf_write_rd__r), .rf_write_data(rf_write_data),
    .rfw_rd__type(rfw_rd__type), .rfw_rd__r(rfw_rd__r), .rfw_data(rfw_data)
  );

  always #5 gip_clock = ~gip_clock;

  int n_cmp = 0;
  int n_bad = 0;
  bit cmp_on = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s t=%0t actual=0x%0h required=0x%0h", name, $time, act, exp);
    end
  endtask

  // Reference model: ALU results form an in-order stream (pending hold first, then the newly
  // accepted one); mem takes the port unless the head of that stream targets the same register.
  typedef struct { logic [2:0] t; logic [4:0] r; logic [31:0] d; } ent_t;
  ent_t hold_q[$];
  ent_t s_q[$];
  ent_t w;
  bit          wr;
  bit          exp_en = 0;
  logic [2:0]  exp_t = '0;
  logic [4:0]  exp_r = '0;
  logic [31:0] exp_d = '0;

  always @(posedge gip_clock) begin
    if (gip_reset) begin
      hold_q.delete();
      exp_en = 0; exp_t = '0; exp_r = '0; exp_d = '0;
    end else begin
      s_q = hold_q;
      if (alu_rd__type != 3'd0 && !(hold_q.size() > 0 && mem_rfw_rd__type != 3'd0))
        s_q.push_back('{alu_rd__type, alu_rd__r,
                        alu_use_shifter ? alu_shifter_result : alu_arith_logic_result});
      wr = 1;
      if (mem_rfw_rd__type != 3'd0 && s_q.size() > 0 &&
          s_q[0].t == mem_rfw_rd__type && s_q[0].r == mem_rfw_rd__r)
        w = s_q.pop_front();
      else if (mem_rfw_rd__type != 3'd0)
        w = '{mem_rfw_rd__type, mem_rfw_rd__r, mem_rfw_data};
      else if (s_q.size() > 0)
        w = s_q.pop_front();
      else
        wr = 0;
      hold_q = s_q;
      exp_en = wr;
      if (wr) begin exp_t = w.t; exp_r = w.r; exp_d = w.d; end
    end
  end

  // Per-cycle compare, sampled mid-low-phase after inputs settle.
  always @(negedge gip_clock) begin
    #2;
    if (cmp_on) begin
      chk("accept", rfw_accepting_alu_rd,
          gip_reset | !(hold_q.size() > 0 && mem_rfw_rd__type != 3'd0));
      chk("wr_en", rf_write_enable, exp_en);
      chk("wr_type", rf_write_rd__type, exp_t);
      chk("wr_r", rf_write_rd__r, exp_r);
      chk("wr_data", rf_write_data, exp_d);
`ifdef GIP_RFW_FORWARD_EN
      if (exp_en) begin
        chk("fwd_type", rfw_rd__type, exp_t);
        chk("fwd_r", rfw_rd__r, exp_r);
        chk("fwd_data", rfw_data, exp_d);
      end else if (hold_q.size() > 0) begin
        chk("fwd_type", rfw_rd__type, hold_q[0].t);
        chk("fwd_r", rfw_rd__r, hold_q[0].r);
        chk("fwd_data", rfw_data, hold_q[0].d);
      end else begin
        chk("fwd_type", rfw_rd__type, 0);
        chk("fwd_r", rfw_rd__r, 0);
        chk("fwd_data", rfw_data, 0);
      end
`else
      chk("fwd_type", rfw_rd__type, 0);
      chk("fwd_r", rfw_rd__r, 0);
      chk("fwd_data", rfw_data, 0);
`endif
    end
  end

  task automatic drive(input logic [2:0] mt, input logic [4:0] mr, input logic [31:0] md,
                       input logic [2:0] at, input logic [4:0] ar, input logic us,
                       input logic [31:0] sh, input logic [31:0] al);
    mem_rfw_rd__type = mt; mem_rfw_rd__r = mr; mem_rfw_data = md;
    alu_rd__type = at; alu_rd__r = ar; alu_use_shifter = us;
    alu_shifter_result = sh; alu_arith_logic_result = al;
  endtask

  task automatic idle();
    drive(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic after_edge();
    @(posedge gip_clock); #1;
  endtask

  initial begin
    idle();
    gip_reset = 1;
    repeat (3) @(posedge gip_clock);
    cmp_on = 1;
    @(negedge gip_clock); gip_reset = 0;

    // ALU only
    drive(0, 0, 0, 1, 3, 1, 32'h1234_5678, 32'hFFFF);
    #1 chk("lit_alu_accept", rfw_accepting_alu_rd, 1);
    after_edge();
    chk("lit_alu_en", rf_write_enable, 1);
    chk("lit_alu_r", rf_write_rd__r, 3);
    chk("lit_alu_data", rf_write_data, 32'h1234_5678);

    // Collision: mem r5 first, ALU r6 deferred
    @(negedge gip_clock); drive(1, 5, 32'hAAAA_0000, 1, 6, 0, 0, 32'h1);
    #1 chk("lit_col_accept", rfw_accepting_alu_rd, 1);
    after_edge();
    chk("lit_col_r1", rf_write_rd__r, 5);
    chk("lit_col_d1", rf_write_data, 32'hAAAA_0000);
    @(negedge gip_clock); idle();
    after_edge();
    chk("lit_col_en2", rf_write_enable, 1);
    chk("lit_col_r2", rf_write_rd__r, 6);
    chk("lit_col_d2", rf_write_data, 32'h1);

    // Stall: hold r6, mem busy 3 cycles, ALU r9 waiting
    @(negedge gip_clock); drive(1, 5, 32'h55, 1, 6, 0, 0, 32'h6);
    for (int i = 0; i < 3; i++) begin
      @(negedge gip_clock); drive(1, 5'(10 + i), 32'(100 + i), 1, 9, 0, 0, 32'h9);
      #1 chk("lit_stall_accept", rfw_accepting_alu_rd, 0);
      after_edge();
      chk("lit_stall_r", rf_write_rd__r, 32'(10 + i));
    end
    @(negedge gip_clock); drive(0, 0, 0, 1, 9, 0, 0, 32'h9);
    #1 chk("lit_unstall_accept", rfw_accepting_alu_rd, 1);
    after_edge();
    chk("lit_hold_r", rf_write_rd__r, 6);
    @(negedge gip_clock); idle();
    after_edge();
    chk("lit_stalled_r", rf_write_rd__r, 9);
    chk("lit_stalled_d", rf_write_data, 32'h9);

    // Supersede: ALU r7 wins over mem r7
    @(negedge gip_clock); drive(1, 7, 32'hDEAD, 1, 7, 0, 0, 32'hBEEF);
    after_edge();
    chk("lit_sup_r", rf_write_rd__r, 7);
    chk("lit_sup_d", rf_write_data, 32'hBEEF);
    @(negedge gip_clock); idle();
    after_edge();
    chk("lit_sup_noextra", rf_write_enable, 0);
    chk("lit_sup_keep_d", rf_write_data, 32'hBEEF);

    // Reset while holding
    @(negedge gip_clock); drive(1, 5, 32'h77, 1, 6, 0, 0, 32'h66);
    @(negedge gip_clock); drive(1, 8, 32'h88, 0, 0, 0, 0, 0); gip_reset = 1;
    #1 chk("lit_rst_accept", rfw_accepting_alu_rd, 1);
    after_edge();
    chk("lit_rst_en", rf_write_enable, 0);
    chk("lit_rst_type", rf_write_rd__type, 0);
    chk("lit_rst_data", rf_write_data, 0);
    @(negedge gip_clock); gip_reset = 0; idle();
    after_edge();
    chk("lit_rst_nohold", rf_write_enable, 0);

    // Randomized traffic over a small register set to provoke supersedes and stalls
    for (int i = 0; i < 2000; i++) begin
      @(negedge gip_clock);
      gip_reset = ($urandom_range(0, 99) == 0);
      drive(($urandom_range(0, 2) == 0) ? 3'd0 : 3'($urandom_range(1, 2)),
            5'($urandom_range(0, 3)), $urandom,
            ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom_range(1, 2)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom, $urandom);
    end
    @(negedge gip_clock); gip_reset = 0; idle();
    repeat (3) @(posedge gip_clock);
    @(negedge gip_clock); #3;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/gip_rfw_writeback.md
# gip_rfw_writeback

Register-file write-back stage of the GIP pipeline, directly downstream of the ALU stage. It merges the ALU result stream and the memory-read result stream onto the single register-file write port. It holds one deferred ALU result when memory wins arbitration, and back-pressures the ALU through `rfw_accepting_alu_rd`. Optionally it publishes the most recent write for forwarding to the register-read stage.

## Interface
Parameters:
- `DATA_WIDTH`, 32, register data width.
- `RD_TYPE_NONE`, 3'b000, rd type value meaning "no write".

Ports:
- `gip_clock`  in  1  pipeline clock; only clock.
- `gip_reset`  in  1  reset; synchronous, active-high.
- `alu_rd__type`  in  3  ALU destination type; `RD_TYPE_NONE` = no result.
- `alu_rd__r`  in  5  ALU destination register.
- `alu_use_shifter`  in  1  1 selects `alu_shifter_result`, 0 selects `alu_arith_logic_result`.
- `alu_shifter_result`  in  32  shifter output.
- `alu_arith_logic_result`  in  32  arith/logic output.
- `mem_rfw_rd__type`  in  3  memory-read destination type; `RD_TYPE_NONE` = none.
- `mem_rfw_rd__r`  in  5  memory-read destination register.
- `mem_rfw_data`  in  32  memory-read data.
- `rfw_accepting_alu_rd`  out  1  combinational; ALU result this cycle is taken.
- `rf_write_enable`  out  1  registered write strobe.
- `rf_write_rd__type`  out  3  registered write type.
- `rf_write_rd__r`  out  5  registered write register.
- `rf_write_data`  out  32  registered write data.
- `rfw_rd__type`  out  3  forwarding: last written type (see Configuration).
- `rfw_rd__r`  out  5  forwarding: last written register.
- `rfw_data`  out  32  forwarding: last written data.

## Operation
- ALU valid = `alu_rd__type != RD_TYPE_NONE`. Mem valid = `mem_rfw_rd__type != RD_TYPE_NONE`. ALU data is the `alu_use_shifter` mux, sampled when the result is accepted.
- State: one hold entry (`hold_valid`, type, r, data).
- `rfw_accepting_alu_rd = !hold_valid | !mem_valid`. This value is independent of ALU valid.
- Memory results cannot be stalled and are never dropped, except under the supersede rule below.
- Write-port priority per cycle is mem, then hold, then incoming ALU:
  - Mem valid, hold empty: write mem. An accepted ALU result goes to hold.
  - Mem valid, hold full: write mem. Hold is retained. ALU is not accepted.
  - Mem invalid, hold full: write hold. An accepted ALU result replaces hold; otherwise hold clears.
  - Mem invalid, hold empty: write the accepted ALU result directly.
- Supersede rule: if the mem result and the ALU result about to be deferred (or the current hold) have equal type and r, the mem write is discarded. The younger ALU result is written this cycle instead. Nothing is deferred for that destination.
- Nothing valid: `rf_write_enable` = 0 next cycle. Type, r and data outputs hold their previous values.

## Timing
- Write-port outputs register the arbitration result. Latency is 1 cycle from an accepted input to `rf_write_enable`.
- Latency of a deferred ALU result is 2 or more cycles. Throughput is one write per cycle.
- `rfw_accepting_alu_rd` is combinational from `mem_rfw_rd__type` and `hold_valid`. It has no path from ALU inputs.
- Reset (synchronous, has priority over all other activity) sets:
  - `hold_valid` = 0 (a pending hold is lost);
  - `rf_write_enable` = 0;
  - all rd types = `RD_TYPE_NONE`;
  - r = 0;
  - all data outputs = 0.
- `rfw_accepting_alu_rd` is 1 during reset.
- Hold full while mem is valid every cycle: the ALU is stalled indefinitely, with no loss or reordering.

## Configuration
- `GIP_RFW_FORWARD_EN` defined:
  - `rfw_rd__*` and `rfw_data` mirror the write-port outputs (same cycle, same values) when `rf_write_enable` = 1.
  - Otherwise they show the hold entry if `hold_valid`, else `RD_TYPE_NONE`.
- Not defined:
  - `rfw_rd__type` is tied to `RD_TYPE_NONE`, `rfw_rd__r` to 0, `rfw_data` to 0.
  - No forwarding logic is synthesised.

## Test plan
- ALU only: rd r3, type 1, use_shifter = 1, shifter = 0x12345678 -> next cycle enable = 1, r = 3, data = 0x12345678. Accept held at 1 throughout.
- Collision: mem r5 = 0xAAAA0000 and ALU r6 = 0x1 in the same cycle -> cycle+1 writes r5, cycle+2 writes r6. Accept = 1.
- Stall: hold full (r6) and mem valid for 3 cycles -> accept = 0 for 3 cycles. Then hold r6 is written, then the stalled ALU result. Order is preserved.
- Supersede: mem r7 = 0xDEAD and ALU r7 = 0xBEEF in the same cycle -> single write r7 = 0xBEEF. Hold stays empty.
- Reset mid-hold: hold full, `gip_reset` = 1 for 1 cycle -> no write of the held value. All outputs at reset values. Accept = 1.
- Forwarding: with `GIP_RFW_FORWARD_EN`, the `rfw_*` outputs equal the write port on every write. Without it, they stay NONE/0 across all of the above.
